// File: rtl/axi_console_uart_tx_pkg.sv
// Shared encodings for the AXI console UART: FSM states, write classes,
// BRESP codes, console address default and write-lane decode helpers.
package axi_console_uart_tx_pkg;

  localparam logic [39:0] CONSOLE_ADDR_DEFAULT = 40'h00_01ff_fff0;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLS_CON   = 2'd0,
    CLS_BURST = 2'd1,
    CLS_MISS  = 2'd2
  } cls_e;

  typedef struct packed {
    logic       ok;
    logic [1:0] lane;
  } lane_t;

  // Only a 32-bit-aligned word store hits the console; its low byte is the character.
  function automatic lane_t strb_lane(input logic [15:0] strb);
    lane_t r;
    r.ok   = 1'b1;
    r.lane = 2'd0;
    case (strb)
      16'h000f: r.lane = 2'd0;
      16'h00f0: r.lane = 2'd1;
      16'h0f00: r.lane = 2'd2;
      16'hf000: r.lane = 2'd3;
      default:  r.ok   = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [127:0] data, input logic [1:0] lane);
    return data[{lane, 5'd0} +: 8];
  endfunction

endpackage

// File: rtl/axi_console_uart_tx_ser.sv
// UART 8N1 serializer: byte_valid/byte_ready handshake, CLK_DIV clocks per bit,
// reloads in the last stop-bit cycle so queued bytes go out back-to-back.
module axi_console_uart_tx_ser #(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       uart_tx,
  output logic       busy
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic          busy_q;
  logic          tx_q;
  logic [3:0]    bit_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    sh_q;
  logic          bit_end;
  logic          frame_end;
  logic          load;

  assign bit_end    = (cnt_q == CNT_LAST);
  assign frame_end  = busy_q & bit_end & (bit_q == 4'd9);
  assign byte_ready = ~busy_q | frame_end;
  assign load       = byte_valid & byte_ready;

  // bit_q: 0 = start, 1..8 = d0..d7, 9 = stop
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      busy_q <= 1'b0;
      tx_q   <= 1'b1;
      bit_q  <= 4'd0;
      cnt_q  <= '0;
    end else if (load) begin
      busy_q <= 1'b1;
      tx_q   <= 1'b0;
      bit_q  <= 4'd0;
      cnt_q  <= '0;
    end else if (busy_q) begin
      if (bit_end) begin
        cnt_q <= '0;
        if (bit_q == 4'd9) begin
          busy_q <= 1'b0;
          tx_q   <= 1'b1;
        end else begin
          bit_q <= bit_q + 4'd1;
          tx_q  <= (bit_q < 4'd8) ? sh_q[0] : 1'b1;
        end
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      sh_q <= byte_data;
    end else if (busy_q && bit_end && bit_q < 4'd8) begin
      sh_q <= {1'b0, sh_q[7:1]};
    end
  end

  assign uart_tx = tx_q;
  assign busy    = busy_q;

endmodule

// File: rtl/axi_console_uart_tx.sv
// AXI3 write responder for the console address: buffers stored bytes in a FIFO and
// sends them as UART 8N1. Define CONSOLE_SIM_PRINT_EN to also $write each pushed byte.
module axi_console_uart_tx
  import axi_console_uart_tx_pkg::*;
#(
  parameter logic [39:0] CONSOLE_ADDR = CONSOLE_ADDR_DEFAULT,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CLK_DIV      = 868
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [39:0]                   awaddr,
  input  logic [3:0]                    awlen,
  input  logic [7:0]                    awid,
  input  logic                          wvalid,
  output logic                          wready,
  input  logic [127:0]                  wdata,
  input  logic [15:0]                   wstrb,
  input  logic                          wlast,
  output logic                          bvalid,
  input  logic                          bready,
  output logic [7:0]                    bid,
  output logic [1:0]                    bresp,
  output logic                          uart_tx,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  state_e        state_q;
  cls_e          cls_q;
  logic [3:0]    len_q;
  logic [3:0]    beat_q;
  logic [7:0]    bid_q;
  logic [1:0]    bresp_q;
  logic          awready_q;
  logic          bvalid_q;

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          addr_hit;
  logic          aw_hs;
  logic          w_hs;
  logic          w_last;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          ser_ready;
  logic          ser_busy;
  lane_t         lane;
  logic [7:0]    push_byte;
  logic          unused_bits;

  assign addr_hit  = (awaddr[39:4] == CONSOLE_ADDR[39:4]);
  assign aw_hs     = awvalid & awready_q;
  assign wready    = (state_q == ST_DATA) & ((cls_q != CLS_CON) | ~fifo_full);
  assign w_hs      = wvalid & wready;
  // wlast only matters up to the announced beat count
  assign w_last    = wlast | (beat_q == len_q);
  assign lane      = strb_lane(wstrb);
  assign push_byte = lane_byte(wdata, lane.lane);
  assign push      = w_hs & (cls_q == CLS_CON) & lane.ok;

  assign unused_bits = ^{awaddr[3:0], wdata};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= ST_IDLE;
      cls_q     <= CLS_MISS;
      len_q     <= 4'd0;
      beat_q    <= 4'd0;
      bid_q     <= 8'd0;
      bresp_q   <= BRESP_OKAY;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          awready_q <= 1'b1;
          if (aw_hs) begin
            state_q   <= ST_DATA;
            awready_q <= 1'b0;
            bid_q     <= awid;
            len_q     <= awlen;
            beat_q    <= 4'd0;
            if (!addr_hit)          cls_q <= CLS_MISS;
            else if (awlen == 4'd0) cls_q <= CLS_CON;
            else                    cls_q <= CLS_BURST;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            beat_q <= beat_q + 4'd1;
            if (w_last) begin
              state_q  <= ST_RESP;
              bvalid_q <= 1'b1;
              case (cls_q)
                CLS_CON:   bresp_q <= lane.ok ? BRESP_OKAY : BRESP_SLVERR;
                CLS_BURST: bresp_q <= BRESP_SLVERR;
                default:   bresp_q <= BRESP_DECERR;
              endcase
            end
          end
        end
        ST_RESP: begin
          if (bready) begin
            state_q   <= ST_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Character FIFO: extra pointer bit distinguishes full from empty
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = ~fifo_empty & ser_ready;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_byte;
  end

  axi_console_uart_tx_ser #(
    .CLK_DIV (CLK_DIV)
  ) u_ser (
    .clk        (clk),
    .rst_b      (rst_b),
    .byte_valid (~fifo_empty),
    .byte_data  (mem_q[rd_ptr_q[AW-1:0]]),
    .byte_ready (ser_ready),
    .uart_tx    (uart_tx),
    .busy       (ser_busy)
  );

`ifdef CONSOLE_SIM_PRINT_EN
  always @(posedge clk) begin
    if (rst_b && push) $write("%c", push_byte);
  end
`else
  // Hardware-only build: the UART is the sole console output.
`endif

  assign awready    = awready_q;
  assign bvalid     = bvalid_q;
  assign bid        = bid_q;
  assign bresp      = bresp_q;
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign tx_busy    = ser_busy | ~fifo_empty;

endmodule

// File: tb/tb_axi_console_uart_tx.sv
// Directed bench for axi_console_uart_tx: AXI write classes, FIFO backpressure,
// UART framing/back-to-back timing and asynchronous reset mid-frame.
`timescale 1ns/1ps
module tb_axi_console_uart_tx;

  localparam int          DEPTH = 16;
  localparam int          DIV   = 16;
  localparam int          LW    = $clog2(DEPTH) + 1;
  localparam logic [39:0] CON_A = 40'h00_01ff_fff0;
  localparam int          TMO   = 40 * DIV;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [39:0]   awaddr = '0;
  logic [3:0]    awlen = '0;
  logic [7:0]    awid = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [127:0]  wdata = '0;
  logic [15:0]   wstrb = '0;
  logic          wlast = 1'b0;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [7:0]    bid;
  logic [1:0]    bresp;
  logic          uart_tx;
  logic [LW-1:0] fifo_level;
  logic          tx_busy;

  axi_console_uart_tx #(
    .CONSOLE_ADDR (CON_A),
    .FIFO_DEPTH   (DEPTH),
    .CLK_DIV      (DIV)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .awvalid    (awvalid),
    .awready    (awready),
    .awaddr     (awaddr),
    .awlen      (awlen),
    .awid       (awid),
    .wvalid     (wvalid),
    .wready     (wready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wlast      (wlast),
    .bvalid     (bvalid),
    .bready     (bready),
    .bid        (bid),
    .bresp      (bresp),
    .uart_tx    (uart_tx),
    .fifo_level (fifo_level),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_rst = 0;
  always @(negedge rst_b) n_rst <= n_rst + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART receiver: samples mid-bit, drops any frame overlapped by a reset
  logic [7:0] rx_q [$];
  int         st_q [$];
  int         frm_err = 0;

  initial begin : uart_mon
    logic       prev;
    logic       ok;
    logic [7:0] b;
    int         r0;
    int         t0;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0 && prev) begin
        t0 = cyc;
        r0 = n_rst;
        ok = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        if (uart_tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (DIV) @(negedge clk);
        if (uart_tx !== 1'b1) ok = 1'b0;
        if (n_rst == r0) begin
          rx_q.push_back(b);
          st_q.push_back(t0);
          if (!ok) frm_err++;
        end
        prev = 1'b1;
      end else begin
        prev = (uart_tx !== 1'b0);
      end
    end
  end

  function automatic logic [127:0] put_byte(input int lane, input logic [7:0] ch);
    logic [127:0] d;
    d = {16{8'hee}};
    d[lane*32 +: 8] = ch;
    return d;
  endfunction

  task automatic aw_send(input logic [39:0] a, input logic [3:0] l, input logic [7:0] id);
    int n;
    n = 0;
    awaddr = a; awlen = l; awid = id; awvalid = 1'b1;
    while (awready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check("aw_timeout", {63'd0, awready}, 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [127:0] d, input logic [15:0] s, input logic last,
                        output int waits, output logic [LW-1:0] lvl);
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    waits = 0;
    while (wready !== 1'b1 && waits < TMO) begin @(negedge clk); waits++; end
    if (waits >= TMO) check("w_timeout", {63'd0, wready}, 64'd1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    lvl = fifo_level;
  endtask

  task automatic b_recv(input logic [1:0] er, input logic [7:0] eid, input string tag);
    int n;
    n = 0;
    bready = 1'b1;
    while (bvalid !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    check({tag, "_bvalid"}, {63'd0, bvalid}, 64'd1);
    check({tag, "_bresp"}, {62'd0, bresp}, {62'd0, er});
    check({tag, "_bid"}, {56'd0, bid}, {56'd0, eid});
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic con_write(input int lane, input logic [7:0] ch, input logic [7:0] id,
                           output logic [LW-1:0] lvl);
    int w;
    aw_send(CON_A, 4'd0, id);
    w_send(put_byte(lane, ch), 16'h000f << (lane * 4), 1'b1, w, lvl);
    b_recv(2'b00, id, "con");
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin @(negedge clk); k++; end
    check("rx_count", rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (tx_busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    check("tx_idle", {63'd0, tx_busy}, 64'd0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [LW-1:0] lvl;
    int            w;
    int            base;
    int            t_h;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", {63'd0, awready}, 64'd0);
    check("rst_wready", {63'd0, wready}, 64'd0);
    check("rst_bvalid", {63'd0, bvalid}, 64'd0);
    check("rst_bid", {56'd0, bid}, 64'd0);
    check("rst_bresp", {62'd0, bresp}, 64'd0);
    check("rst_uart_tx", {63'd0, uart_tx}, 64'd1);
    check("rst_level", {59'd0, fifo_level}, 64'd0);
    check("rst_busy", {63'd0, tx_busy}, 64'd0);
    rst_b = 1'b1;
    @(negedge clk);
    check("awready_after_rst", {63'd0, awready}, 64'd1);

    // 1: single console char 'A' on lane 1
    aw_send(CON_A, 4'd0, 8'h5a);
    w_send(put_byte(1, 8'h41), 16'h00f0, 1'b1, w, lvl);
    check("t1_level", {59'd0, lvl}, 64'd1);
    b_recv(2'b00, 8'h5a, "t1");
    wait_rx(1, 20 * DIV);
    check("t1_byte", {56'd0, rx_q[0]}, 64'h41);
    wait_idle(20 * DIV);
    check("t1_idle_high", {63'd0, uart_tx}, 64'd1);

    // 2: primer occupies the UART, then 17 chars: 16 fill the FIFO, the 17th waits
    base = rx_q.size();
    con_write(0, 8'h30, 8'h10, lvl);
    for (int k = 1; k <= 16; k++) begin
      con_write(k % 4, 8'(8'h40 + k), 8'(8'h10 + k), lvl);
      check($sformatf("t2_level%0d", k), {59'd0, lvl}, 64'(k));
    end
    aw_send(CON_A, 4'd0, 8'h21);
    check("t2_peak", {59'd0, fifo_level}, 64'd16);
    check("t2_wready_full", {63'd0, wready}, 64'd0);
    w_send(put_byte(1, 8'h51), 16'h00f0, 1'b1, w, lvl);
    check("t2_blocked", {63'd0, (w > 0)}, 64'd1);
    check("t2_level_after", {59'd0, lvl}, 64'd16);
    b_recv(2'b00, 8'h21, "t2");
    wait_rx(base + 18, 20 * 10 * DIV);
    check("t2_primer", {56'd0, rx_q[base]}, 64'h30);
    for (int k = 1; k <= 17; k++)
      check($sformatf("t2_char%0d", k), {56'd0, rx_q[base+k]}, 64'(8'h40 + k));
    wait_idle(20 * DIV);

    // 3: decode miss and console burst
    base = rx_q.size();
    aw_send(40'h00_8000_0000, 4'd0, 8'h33);
    w_send(put_byte(0, 8'h5a), 16'h000f, 1'b1, w, lvl);
    check("t3_miss_level", {59'd0, lvl}, 64'd0);
    b_recv(2'b11, 8'h33, "t3m");
    aw_send(CON_A, 4'd3, 8'h44);
    for (int k = 0; k < 4; k++) begin
      w_send(put_byte(0, 8'h61), 16'h000f, 1'b0, w, lvl);
      check($sformatf("t3_burst_level%0d", k), {59'd0, lvl}, 64'd0);
      if (k == 2) check("t3_more_beats", {63'd0, wready}, 64'd1);
    end
    b_recv(2'b10, 8'h44, "t3b");

    // 4: bad strobe; response held while bready low
    aw_send(CON_A, 4'd0, 8'hc3);
    w_send(put_byte(0, 8'h77), 16'h0003, 1'b1, w, lvl);
    check("t4_level", {59'd0, lvl}, 64'd0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_hold_bvalid%0d", k), {63'd0, bvalid}, 64'd1);
      check($sformatf("t4_hold_bid%0d", k), {56'd0, bid}, 64'hc3);
      check($sformatf("t4_hold_bresp%0d", k), {62'd0, bresp}, 64'h2);
      @(negedge clk);
    end
    b_recv(2'b10, 8'hc3, "t4");
    check("t4_bvalid_drop", {63'd0, bvalid}, 64'd0);
    repeat (12 * DIV) @(negedge clk);
    check("t3_t4_no_tx", rx_q.size(), base);
    check("t4_tx_high", {63'd0, uart_tx}, 64'd1);
    check("t4_busy", {63'd0, tx_busy}, 64'd0);

    // 5: "Hi" back-to-back
    base = rx_q.size();
    con_write(2, 8'h48, 8'h01, lvl);
    con_write(3, 8'h69, 8'h02, lvl);
    wait_rx(base + 2, 30 * DIV);
    check("t5_H", {56'd0, rx_q[base]}, 64'h48);
    check("t5_i", {56'd0, rx_q[base+1]}, 64'h69);
    t_h = st_q[base];
    check("t5_start_gap", st_q[base+1] - t_h, 10 * DIV);
    wait_idle(20 * DIV);
    check("t5_total", cyc - t_h, 20 * DIV);

    // 6: reset during a start bit with a second char queued
    base = rx_q.size();
    con_write(0, 8'h52, 8'h03, lvl);
    con_write(1, 8'h53, 8'h04, lvl);
    check("t6_queued", {59'd0, lvl}, 64'd1);
    check("t6_start_bit", {63'd0, uart_tx}, 64'd0);
    #1 rst_b = 1'b0;
    #1;
    check("t6_rst_tx", {63'd0, uart_tx}, 64'd1);
    check("t6_rst_level", {59'd0, fifo_level}, 64'd0);
    check("t6_rst_busy", {63'd0, tx_busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    check("t6_discarded", rx_q.size(), base);
    con_write(0, 8'h5a, 8'h05, lvl);
    wait_rx(base + 1, 20 * DIV);
    check("t6_after_rst", {56'd0, rx_q[base]}, 64'h5a);
    wait_idle(20 * DIV);

    check("frame_errors", frm_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
